// File: rtl/core_ram_drain_pkg.sv
// Shared sizing for the per-core ping-pong RAM, the butterfly cores and the bank drain sequencer.
package core_ram_drain_pkg;

    localparam int unsigned LOG_CORE_COUNT = 5;
    localparam int unsigned LOG_N          = 12;
    localparam int unsigned DATA_W         = 60;

    // Each core owns 4 coefficients per address row, hence the +2.
    function automatic int unsigned calc_aw(input int unsigned log_n, input int unsigned log_cores);
        return log_n - (log_cores + 2);
    endfunction

    localparam int unsigned AW    = calc_aw(LOG_N, LOG_CORE_COUNT);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } drain_state_e;

endpackage

// File: rtl/core_ram_drain_skid_fifo2.sv
// Two-entry register FIFO that absorbs the RAM read latency and output backpressure.
module skid_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic         head_valid,
    output logic [W-1:0] head_data
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop && (cnt_q != 2'd0);
    assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);

    // Next entry contents; e0 is always the head.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = push_data;
                else               e1_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = push_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0_q       <= '0;
            e1_q       <= '0;
            cnt_q      <= 2'd0;
            head_valid <= 1'b0;
        end else begin
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            cnt_q      <= cnt_d;
            head_valid <= (cnt_d != 2'd0);
        end
    end

    assign count     = cnt_q;
    assign head_data = e0_q;

endmodule

// File: rtl/core_ram_drain.sv
// Walks every address of one RAM bank and streams the read data out as valid/ready beats.
import core_ram_drain_pkg::*;

module core_ram_drain #(
    parameter  int unsigned LOG_CORE_COUNT = core_ram_drain_pkg::LOG_CORE_COUNT,
    parameter  int unsigned LOG_N          = core_ram_drain_pkg::LOG_N,
    parameter  int unsigned DATA_W         = core_ram_drain_pkg::DATA_W,
    localparam int unsigned AW             = calc_aw(LOG_N, LOG_CORE_COUNT),
    localparam int unsigned DEPTH          = 1 << AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bank,
    output logic              busy,
    output logic              done,
    output logic              ram_read_select,
    output logic [AW-1:0]     ram_read_address,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [AW-1:0]     m_index,
    output logic              m_last
);

    localparam int unsigned PW = DATA_W + AW + 1;

    drain_state_e  state_q, state_d;
    logic [AW:0]   addr_q, addr_d;
    logic          sel_q, sel_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] tag_q, tag_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [1:0]    fifo_count;
    logic [PW-1:0] fifo_head;
    logic [PW-1:0] fifo_push_data;
    logic          pop_c;
    logic          credit_c;
    logic          issue_c;

    assign pop_c    = m_valid & m_ready;
    // Queued beats plus the read still in the RAM pipe must leave room for one more.
    assign credit_c = ((3'(fifo_count) + 3'(inflight_q) - 3'(pop_c)) < 3'd2);
    assign issue_c  = (state_q == ST_RUN) && !addr_q[AW] && credit_c;

    // Next-state, read issue and completion.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        inflight_d = issue_c;
        tag_d      = issue_c ? addr_q[AW-1:0] : tag_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d   = bank;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue_c) addr_d = addr_q + (AW+1)'(1);
                if (pop_c && m_last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and control registers; reset also discards any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            sel_q      <= 1'b0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fifo_push_data = {ram_data_in, tag_q, (tag_q == AW'(DEPTH - 1))};

    skid_fifo2 #(
        .W (PW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_q),
        .push_data  (fifo_push_data),
        .pop        (pop_c),
        .count      (fifo_count),
        .head_valid (m_valid),
        .head_data  (fifo_head)
    );

    assign {m_data, m_index, m_last} = fifo_head;
    assign busy             = busy_q;
    assign done             = done_q;
    assign ram_read_select  = sel_q;
    assign ram_read_address = addr_q[AW-1:0];

endmodule

// File: tb/tb_core_ram_drain.sv
// Directed bench for core_ram_drain with a registered-read two-bank RAM model.
module tb_core_ram_drain;

    localparam int unsigned AW     = 5;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned DATA_W = 60;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              bank;
    logic              busy;
    logic              done;
    logic              ram_read_select;
    logic [AW-1:0]     ram_read_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [AW-1:0]     m_index;
    logic              m_last;

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    int total = 0;
    int bad   = 0;

    core_ram_drain dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .bank             (bank),
        .busy             (busy),
        .done             (done),
        .ram_read_select  (ram_read_select),
        .ram_read_address (ram_read_address),
        .ram_data_in      (ram_data_in),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_index          (m_index),
        .m_last           (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one-cycle registered read.
    always @(posedge clk)
        ram_data_in <= ram_read_select ? mem1[ram_read_address] : mem0[ram_read_address];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy), 0);
        check({tag, "_done"},  64'(done), 0);
        check({tag, "_valid"}, 64'(m_valid), 0);
        check({tag, "_last"},  64'(m_last), 0);
        check({tag, "_data"},  64'(m_data), 0);
        check({tag, "_index"}, 64'(m_index), 0);
        check({tag, "_addr"},  64'(ram_read_address), 0);
        check({tag, "_sel"},   64'(ram_read_select), 0);
    endtask

    // Ends on the negedge of the cycle after start is sampled.
    task automatic start_pulse(input logic b);
        start = 1'b1;
        bank  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready high, 1: random ~40% ready, 2: 50-cycle stall at first beat, 3: ready high with bank toggling.
    task automatic run_drain(input logic b, input logic [DATA_W-1:0] base, input int mode,
                             input int busy_start_at, input bit restart, input int abort_at,
                             input int exp_done_cyc);
        int  exp_idx    = 0;
        int  cyc        = 1;
        int  first_v    = -1;
        int  stall_left = 0;
        bit  stalled    = 0;
        bit  pulsed     = 0;
        bit  fin        = 0;
        while (!fin) begin
            if (cyc > 3000) begin
                check("timeout", 0, 1);
                fin = 1;
            end else if (done) begin
                check("beats_at_done", 64'(exp_idx), DEPTH);
                check("busy_at_done", 64'(busy), 0);
                if (exp_done_cyc >= 0) check("done_cycle", 64'(cyc), 64'(exp_done_cyc));
                if (mode == 0 || mode == 3) check("first_valid_cycle", 64'(first_v), 3);
                if (restart) begin
                    start = 1'b1;
                    bank  = b;
                end
                fin = 1;
            end else begin
                check("busy_run", 64'(busy), 1);
                check("sel_hold", 64'(ram_read_select), 64'(b));
                if (m_valid) begin
                    if (first_v < 0) first_v = cyc;
                    check("extra_beat", 64'(exp_idx < 32), 1);
                    check("index", 64'(m_index), 64'(exp_idx % 32));
                    check("data", 64'(m_data), 64'(base) + 64'(exp_idx));
                    check("last", 64'(m_last), 64'(exp_idx == 31));
                end
                if (abort_at >= 0 && m_valid && exp_idx == abort_at) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n   = 1'b1;
                    m_ready = 1'b1;
                    check_all_zero("rst_mid");
                    repeat (5) begin
                        @(negedge clk);
                        check("abort_no_done", 64'(done), 0);
                        check("abort_idle", 64'(busy | m_valid), 0);
                    end
                    fin = 1;
                end else begin
                    case (mode)
                        1: m_ready = ($urandom_range(0, 99) < 40);
                        2: begin
                            if (m_valid && !stalled) begin
                                stalled    = 1;
                                stall_left = 50;
                            end
                            if (stall_left > 0) begin
                                m_ready = 1'b0;
                                check("stall_addr_frozen", 64'(ram_read_address), 2);
                                stall_left--;
                            end else begin
                                m_ready = 1'b1;
                            end
                        end
                        3: begin
                            m_ready = 1'b1;
                            bank    = cyc[0];
                        end
                        default: m_ready = 1'b1;
                    endcase
                    if (busy_start_at >= 0 && !pulsed && m_valid && exp_idx == busy_start_at) begin
                        start  = 1'b1;
                        bank   = ~b;
                        pulsed = 1;
                    end
                    if (m_valid && m_ready) exp_idx++;
                    @(negedge clk);
                    start = 1'b0;
                    cyc++;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem0[i] = DATA_W'(1000 + i);
            mem1[i] = DATA_W'(5000 + i);
        end
        rst_n   = 1'b0;
        start   = 1'b0;
        bank    = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic drain from bank 0.
        start_pulse(1'b0);
        run_drain(1'b0, 1000, 0, -1, 0, -1, 35);
        @(negedge clk);
        check("basic_done_pulse", 64'(done), 0);
        check("basic_idle", 64'(busy), 0);

        // Bank 1 with the bank input toggling mid-drain.
        start_pulse(1'b1);
        run_drain(1'b1, 5000, 3, -1, 0, -1, 35);
        @(negedge clk);

        // Random backpressure.
        start_pulse(1'b0);
        run_drain(1'b0, 1000, 1, -1, 0, -1, -1);
        @(negedge clk);

        // Long stall right after the first beat.
        start_pulse(1'b1);
        run_drain(1'b1, 5000, 2, -1, 0, -1, -1);
        @(negedge clk);

        // Start while busy is ignored; start in the done cycle launches the next drain.
        start_pulse(1'b0);
        run_drain(1'b0, 1000, 0, 10, 1, -1, 35);
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", 64'(busy), 1);
        check("restart_addr", 64'(ram_read_address), 0);
        run_drain(1'b0, 1000, 0, -1, 0, -1, 35);
        @(negedge clk);
        check("restart_idle", 64'(busy), 0);
        check("restart_single_done", 64'(done), 0);

        // Reset in the middle of a drain, then a clean drain.
        start_pulse(1'b1);
        run_drain(1'b1, 5000, 0, -1, 0, 15, -1);
        start_pulse(1'b0);
        run_drain(1'b0, 1000, 0, -1, 0, -1, 35);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
